pattern_tx: RTL and testbench

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx.sv | 126 ++++++++++++
 tb/tb_pattern_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// pattern_tx: serialises a captured bit pattern MSB first, repeating it
// (repeat_n + 1) times with a single idle GAP cycle between sends, and
// finishes with a one-cycle DONE pulse. The serial stream (x, valid) feeds a
// sequence-detector FSM.
//
// Request handshake: start is a level request that is looked at only while
// the FSM sits in IDLE; the rising edge on which IDLE sees start=1 is the
// acceptance edge, and pattern/repeat_n are captured on that same edge.
// There is no separate ready: busy=1 (SHIFT/GAP) or done=1 (DONE) means a
// request is not being accepted, and start is simply ignored in those states.
//
// The repeat-count input is named repeat_n because "repeat" is a reserved
// word in SystemVerilog.
//
// All outputs are decoded from registers (state plus shift-register MSB), so
// there is no combinational path from start/pattern/repeat_n to any output.
module pattern_tx #(
  parameter int WIDTH = 8,  // pattern length in bits, 2..32
  parameter int REP_W = 3   // width of the repeat-count input
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] repeat_n,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       S
);

  // Bit counter only has to reach WIDTH-1 (at most 31).
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_SHIFT = 3'b001,
    ST_GAP   = 3'b010,
    ST_DONE  = 3'b011
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  // State and datapath registers; reset clears everything and wins over start.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Next-state and datapath update rules for each state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Capture into both hold and shift registers so GAP can reload.
        if (start) begin
          state_d   = ST_SHIFT;
          hold_d    = pattern;
          shift_d   = pattern;
          bit_cnt_d = LAST_BIT;
          rep_cnt_d = repeat_n;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q != '0) begin
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end else if (rep_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          rep_cnt_d = rep_cnt_q - REP_W'(1);
          state_d   = ST_GAP;
        end
      end

      ST_GAP: begin
        // One idle bit time, then restart the same pattern.
        shift_d   = hold_q;
        bit_cnt_d = LAST_BIT;
        state_d   = ST_SHIFT;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      // Codes 100-111 are unreachable; recover to IDLE if ever entered.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state and the shift-register MSB.
  always_comb begin
    valid = (state_q == ST_SHIFT);
    x     = (state_q == ST_SHIFT) && shift_q[WIDTH-1];
    busy  = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    done  = (state_q == ST_DONE);
    S     = state_q;
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: each scenario task drives stimulus and compares the
// observed {S, done, busy, valid, x} every cycle against a reference stream
// built from the transmission rules (bits MSB first, gaps between repeats,
// one DONE cycle at the end).
module tb_pattern_tx;
  localparam int WIDTH = 8;
  localparam int REP_W = 3;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] repeat_n;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;
  logic [2:0]       S;

  int tests = 0;
  int fails = 0;

  logic [6:0] exp_q[$];

  localparam logic [6:0] IDLE_OBS = 7'b000_0000;

  pattern_tx #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .x        (x),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .S        (S)
  );

  // Clock
  always #5 CLK = ~CLK;

  function automatic logic [6:0] obs_vec();
    return {S, done, busy, valid, x};
  endfunction

  function automatic logic [6:0] mk(input logic [2:0] s, input logic d,
                                    input logic b, input logic v, input logic xx);
    return {s, d, b, v, xx};
  endfunction

  // Reference: what a complete run looks like cycle by cycle after acceptance.
  function automatic void append_run(input logic [WIDTH-1:0] p, input int r);
    for (int k = 0; k <= r; k++) begin
      for (int i = WIDTH - 1; i >= 0; i--)
        exp_q.push_back(mk(3'b001, 1'b0, 1'b1, 1'b1, p[i]));
      if (k < r) exp_q.push_back(mk(3'b010, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(3'b011, 1'b1, 1'b0, 1'b0, 1'b0));
  endfunction

  // Positions j in the transmitted stream where the last four bits read 1011.
  function automatic logic [WIDTH-1:0] det_mask(input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int j = 3; j < WIDTH; j++)
      if ({p[WIDTH-1-(j-3)], p[WIDTH-1-(j-2)], p[WIDTH-1-(j-1)], p[WIDTH-1-j]} == 4'b1011)
        m[j] = 1'b1;
    return m;
  endfunction

  // Driver: present a request; it is accepted on the next rising edge.
  task automatic drive_start(input logic [WIDTH-1:0] p, input logic [REP_W-1:0] r);
    pattern  = p;
    repeat_n = r;
    start    = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0; pattern = '0; repeat_n = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    tests++;
    if (obs_vec() !== IDLE_OBS) begin
      fails++;
      $display("FAIL reset_state: got %b expected %b", obs_vec(), IDLE_OBS);
    end
    // Reset and start together: reset wins.
    start = 1'b1;
    @(negedge CLK);
    tests++;
    if (obs_vec() !== IDLE_OBS) begin
      fails++;
      $display("FAIL reset_priority: got %b expected %b", obs_vec(), IDLE_OBS);
    end
    // Release reset with start high: accepted, then reset from SHIFT.
    RESET = 1'b0;
    drive_start(8'h3C, 3'd0);
    @(negedge CLK);
    tests++;
    if (obs_vec() !== mk(3'b001, 1'b0, 1'b1, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL reset_release_accept: got %b expected %b", obs_vec(), mk(3'b001, 1'b0, 1'b1, 1'b1, 1'b0));
    end
    RESET = 1'b1;
    @(negedge CLK);
    tests++;
    if (obs_vec() !== IDLE_OBS) begin
      fails++;
      $display("FAIL reset_from_shift: got %b expected %b", obs_vec(), IDLE_OBS);
    end
    RESET = 1'b0; start = 1'b0;
    @(negedge CLK);
    tests++;
    if (obs_vec() !== IDLE_OBS) begin
      fails++;
      $display("FAIL idle_hold: got %b expected %b", obs_vec(), IDLE_OBS);
    end
  endtask

  task automatic test_single();
    logic [6:0] e;
    int n;
    exp_q.delete();
    drive_start(8'b1011_0010, 3'd0);
    append_run(8'b1011_0010, 0);
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      start = 1'b0;
      e = exp_q.pop_front();
      tests++;
      if (obs_vec() !== e) begin
        fails++;
        $display("FAIL single cyc %0d: got %b expected %b", n, obs_vec(), e);
      end
      n++;
    end
    @(negedge CLK);
    tests++;
    if (obs_vec() !== IDLE_OBS) begin
      fails++;
      $display("FAIL single_back_to_idle: got %b expected %b", obs_vec(), IDLE_OBS);
    end
  endtask

  task automatic test_repeat();
    logic [6:0] e;
    int n, busy_cnt, done_cnt;
    exp_q.delete();
    drive_start(8'hA5, 3'd2);
    append_run(8'hA5, 2);
    n = 0; busy_cnt = 0; done_cnt = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      tests++;
      if (obs_vec() !== e) begin
        fails++;
        $display("FAIL repeat cyc %0d: got %b expected %b", n, obs_vec(), e);
      end
      // Noise on the request inputs must not disturb the run.
      if (exp_q.size() > 0) begin
        start    = 1'($urandom_range(0, 1));
        pattern  = WIDTH'($urandom());
        repeat_n = REP_W'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      n++;
    end
    @(negedge CLK);
    tests++;
    if (obs_vec() !== IDLE_OBS) begin
      fails++;
      $display("FAIL repeat_back_to_idle: got %b expected %b", obs_vec(), IDLE_OBS);
    end
    tests++;
    if (busy_cnt != 3 * WIDTH + 2) begin
      fails++;
      $display("FAIL repeat_busy_cycles: got %0d expected %0d", busy_cnt, 3 * WIDTH + 2);
    end
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL repeat_done_pulses: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    int n;
    exp_q.delete();
    drive_start(8'b1011_0010, 3'd0);
    append_run(8'b1011_0010, 0);
    exp_q.push_back(IDLE_OBS);
    append_run(8'hFF, 1);
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      tests++;
      if (obs_vec() !== e) begin
        fails++;
        $display("FAIL back_to_back cyc %0d: got %b expected %b", n, obs_vec(), e);
      end
      if (n == 3) begin
        pattern  = 8'hFF;
        repeat_n = 3'd1;
      end
      if (n >= WIDTH + 2) start = 1'b0;
      n++;
    end
    @(negedge CLK);
    tests++;
    if (obs_vec() !== IDLE_OBS) begin
      fails++;
      $display("FAIL back_to_back_idle: got %b expected %b", obs_vec(), IDLE_OBS);
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    logic [WIDTH-1:0] p;
    logic [REP_W-1:0] r;
    int n;
    for (int run = 0; run < 6; run++) begin
      exp_q.delete();
      p = WIDTH'($urandom());
      r = REP_W'($urandom_range(0, 3));
      drive_start(p, r);
      append_run(p, int'(r));
      n = 0;
      while (exp_q.size() > 0) begin
        @(negedge CLK);
        e = exp_q.pop_front();
        tests++;
        if (obs_vec() !== e) begin
          fails++;
          $display("FAIL random run %0d cyc %0d: got %b expected %b", run, n, obs_vec(), e);
        end
        if (exp_q.size() > 0) begin
          start    = 1'($urandom_range(0, 1));
          pattern  = WIDTH'($urandom());
          repeat_n = REP_W'($urandom());
        end else begin
          start = 1'b0;
        end
        n++;
      end
      @(negedge CLK);
      tests++;
      if (obs_vec() !== IDLE_OBS) begin
        fails++;
        $display("FAIL random run %0d idle: got %b expected %b", run, obs_vec(), IDLE_OBS);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    int stop_at;
    // stop_at = number of observed cycles before RESET is raised.
    for (int v = 0; v < 2; v++) begin
      stop_at = (v == 0) ? 4 : WIDTH + 1;
      exp_q.delete();
      drive_start(WIDTH'($urandom()) | 8'h80, 3'd1);
      append_run(pattern, 1);
      for (int n = 0; n < stop_at; n++) begin
        @(negedge CLK);
        start = 1'b0;
        e = exp_q.pop_front();
        tests++;
        if (obs_vec() !== e) begin
          fails++;
          $display("FAIL reset_mid v%0d cyc %0d: got %b expected %b", v, n, obs_vec(), e);
        end
      end
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      tests++;
      if (obs_vec() !== IDLE_OBS) begin
        fails++;
        $display("FAIL reset_mid v%0d abort: got %b expected %b", v, obs_vec(), IDLE_OBS);
      end
      for (int n = 0; n < 10; n++) begin
        @(negedge CLK);
        tests++;
        if (obs_vec() !== IDLE_OBS) begin
          fails++;
          $display("FAIL reset_mid v%0d after %0d: got %b expected %b", v, n, obs_vec(), IDLE_OBS);
        end
      end
    end
  endtask

  task automatic test_detector();
    logic [3:0] win;
    logic [WIDTH-1:0] det_obs, det_exp;
    int nbits;
    win = '0; det_obs = '0; nbits = 0;
    det_exp = det_mask(8'b1011_0010);
    drive_start(8'b1011_0010, 3'd0);
    for (int n = 0; n < WIDTH + 3; n++) begin
      @(negedge CLK);
      start = 1'b0;
      if (valid === 1'b1) begin
        win = {win[2:0], x};
        if (nbits >= 3 && nbits < WIDTH && win == 4'b1011) det_obs[nbits] = 1'b1;
        nbits++;
      end
    end
    tests++;
    if (nbits != WIDTH) begin
      fails++;
      $display("FAIL detector_bit_count: got %0d expected %0d", nbits, WIDTH);
    end
    tests++;
    if (det_obs !== det_exp) begin
      fails++;
      $display("FAIL detector_positions: got %b expected %b", det_obs, det_exp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_detector();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
